opl2_write_queue: RTL and testbench
===================================

# opl2_write_queue

Host-side write buffer and pacer placed directly upstream of the OPL2 interface block. It accepts register-port writes (address/data, port-select bit) from the host, stores them in a small FIFO, and replays them to the OPL2 interface's `addr`/`din`/`we` inputs. Writes are spaced by the OPL2-mandated recovery times: about 3.3 µs after an address write and about 23 µs after a data write at the 14.318 MHz OPL clock. This lets the host write at full bus speed without software delay loops.

## Interface
- `DEPTH`, default 16: FIFO entries; must be a power of two and at least 2.
- `ADDR_WAIT`, default 48: recovery cycles after an address-port write (opl_addr=0); must be ≥1.
- `DATA_WAIT`, default 330: recovery cycles after a data-port write (opl_addr=1); must be ≥1.
- `WE_HOLD`, default 4: cycles `opl_we` stays high per write; must be ≥1.
- `clk_opl`  in  1  OPL clock, 14.318 MHz.
- `rst_n`  in  1  reset, synchronous, active-low; clock clk_opl.
- `host_valid`  in  1  host write request.
- `host_ready`  out  1  a write is accepted when host_valid && host_ready at a rising edge.
- `host_addr`  in  1  port select: 0 = address register, 1 = data register.
- `host_data`  in  8  write data.
- `flush`  in  1  discards all queued, not-yet-started entries.
- `opl_addr`  out  1  drives the `addr` input of the OPL2 interface.
- `opl_din`  out  8  drives the `din` input of the OPL2 interface.
- `opl_we`  out  1  drives the `we` input of the OPL2 interface; the downstream block edge-detects it.
- `level`  out  $clog2(DEPTH)+1  number of queued entries.
- `busy`  out  1  high when level != 0 or the FSM is not in IDLE.

## Operation
- Each FIFO entry is 9 bits: {addr, data}. Entries replay in strict arrival order.
- `host_ready` = !full && !flush && rst_n. There is no bypass: a push and a pop in the same cycle while the FIFO is full is not allowed.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop, register the entry onto opl_addr/opl_din, and go to SETUP.
  - SETUP: 1 cycle; opl_we=0, data already stable on opl_addr/opl_din.
  - STROBE: WE_HOLD cycles; opl_we=1.
  - WAIT: opl_we=0, a down-counter is loaded with ADDR_WAIT or DATA_WAIT, selected by the opl_addr of the current entry.
- On the last WAIT cycle: if the FIFO is non-empty, pop and go straight to SETUP; otherwise go to IDLE.
- opl_addr and opl_din hold their value from the pop until the next pop. They never change while opl_we=1.
- flush clears the FIFO pointers and level at the next edge. An entry already popped (SETUP, STROBE or WAIT) completes normally, including its full WAIT.
- flush and host_valid in the same cycle: flush wins and the write is not accepted (host_ready=0).
- Width rules:
  - level counts 0..DEPTH inclusive.
  - The wait counter width is $clog2(max(ADDR_WAIT,DATA_WAIT)+1).
  - The hold counter width is $clog2(WE_HOLD+1).

## Timing
- Reset values: opl_addr=0, opl_din=0, opl_we=0, level=0, busy=0, FSM=IDLE, host_ready=0 while rst_n=0.
- Reset mid-operation aborts the current write at the next edge (opl_we=0 immediately) and discards the FIFO contents.
- Latency into an empty, idle queue, with the push accepted at edge E0:
  - level=1 after E0.
  - Pop at E1: opl_addr/opl_din valid, level=0.
  - opl_we rises after E2 and stays high for exactly WE_HOLD cycles.
- Spacing between consecutive opl_we rising edges while the queue is backlogged: 1 + WE_HOLD + W, where W is the recovery of the earlier entry.
  - Defaults: address write followed by anything = 53 cycles; data write followed by anything = 335 cycles.
- opl_we low time between strobes is always ≥2 cycles, which guarantees the downstream rising-edge detector sees every write.

## Configuration
- `OPL2_WQ_PACING_EN`:
  - Defined: WAIT uses ADDR_WAIT/DATA_WAIT as described above.
  - Undefined: WAIT is a fixed 1 cycle for both ports, giving back-to-back replay at 1+WE_HOLD+1 cycles spacing (6 at defaults). The ADDR_WAIT/DATA_WAIT parameters are ignored and the wait counter is removed.

## Structure
- Shared package `opl2_pkg` holds:
  - typedef `opl2_wq_entry_t`: packed struct {addr, data[7:0]}.
  - enum `opl2_wq_state_t`: IDLE, SETUP, STROBE, WAIT.
  - Default timing constants `OPL2_ADDR_WAIT_CYC`=48, `OPL2_DATA_WAIT_CYC`=330.
- One sub-module, `opl2_wq_fifo`: synchronous single-clock FIFO with push, pop, flush, full, empty and level outputs; DEPTH parameter; 9-bit entries.
- The top level contains the FSM, the hold counter and the wait counter.

## Test plan
- Reset, then one push {0,0x20} at E0:
  - opl_addr=0 and opl_din=0x20 after E1.
  - opl_we high for cycles E2+1..E2+4.
  - busy falls 48 cycles after opl_we falls.
- Backlog pushes {0,0xB0}, {1,0x31}, {0,0xA0}:
  - opl_we rising edges spaced 53 then 335 cycles.
  - din sequence B0, 31, A0.
- Fill 16 entries without draining:
  - host_ready=0 with level=16.
  - A 17th host_valid is not accepted.
  - After the first pop, host_ready=1 the next cycle.
- Assert flush during STROBE of entry 1 with 5 queued:
  - Entry 1 completes its strobe and WAIT.
  - level=0 next cycle; no further opl_we pulses.
- rst_n low during WAIT: opl_we=0, level=0, busy=0 after the edge; pushes are accepted again once rst_n=1.
- Build with OPL2_WQ_PACING_EN undefined, backlog 3 writes: rising edges spaced 6 cycles.

Source files
------------

// File: rtl/opl2_pkg.sv
// Shared types and default recovery timings for the OPL2 host write path.
package opl2_pkg;

  localparam int OPL2_ADDR_WAIT_CYC = 48;
  localparam int OPL2_DATA_WAIT_CYC = 330;

  typedef struct packed {
    logic       addr;
    logic [7:0] data;
  } opl2_wq_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    WAIT
  } opl2_wq_state_t;

endpackage

// File: rtl/opl2_wq_fifo.sv
// Single-clock FIFO of {addr, data} register writes with synchronous flush.
module opl2_wq_fifo
  import opl2_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk_opl,
  input  logic                     rst_n,
  input  logic                     push,
  input  opl2_wq_entry_t           wdata,
  input  logic                     pop,
  input  logic                     flush,
  output opl2_wq_entry_t           rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  opl2_wq_entry_t mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign rdata   = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk_opl) begin
    if (do_push && !flush && rst_n) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Flush drops every stored entry; anything already popped lives on in the top's registers.
  always_ff @(posedge clk_opl) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/opl2_write_queue.sv
// Buffers host writes and replays them to the OPL2 interface with recovery spacing.
// Define OPL2_WQ_PACING_EN for per-port recovery waits; otherwise WAIT lasts one cycle.
module opl2_write_queue
  import opl2_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int ADDR_WAIT = OPL2_ADDR_WAIT_CYC,
  parameter int DATA_WAIT = OPL2_DATA_WAIT_CYC,
  parameter int WE_HOLD   = 4
) (
  input  logic                   clk_opl,
  input  logic                   rst_n,
  input  logic                   host_valid,
  output logic                   host_ready,
  input  logic                   host_addr,
  input  logic [7:0]             host_data,
  input  logic                   flush,
  output logic                   opl_addr,
  output logic [7:0]             opl_din,
  output logic                   opl_we,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy
);

  localparam int                HOLD_W    = $clog2(WE_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(WE_HOLD - 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || WE_HOLD < 1 || ADDR_WAIT < 1 || DATA_WAIT < 1) begin : g_bad_param
    $error("opl2_write_queue: illegal parameter combination");
  end

  opl2_wq_state_t    state;
  opl2_wq_state_t    state_next;
  opl2_wq_entry_t    fifo_rdata;
  opl2_wq_entry_t    fifo_wdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              wait_last;
  logic [HOLD_W-1:0] hold_cnt;

  assign host_ready = !fifo_full && !flush && rst_n;
  assign fifo_wdata = '{addr: host_addr, data: host_data};

  opl2_wq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_opl (clk_opl),
    .rst_n   (rst_n),
    .push    (host_valid && host_ready),
    .wdata   (fifo_wdata),
    .pop     (pop),
    .flush   (flush),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  // A pop suppressed by flush keeps the flushed entry from sneaking out.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty && !flush) begin
          pop        = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP:  state_next = STROBE;
      STROBE: if (hold_cnt == '0) state_next = WAIT;
      WAIT: begin
        if (wait_last) begin
          if (!fifo_empty && !flush) begin
            pop        = 1'b1;
            state_next = SETUP;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_opl) begin
    if (!rst_n) begin
      state    <= IDLE;
      opl_addr <= 1'b0;
      opl_din  <= 8'h00;
      hold_cnt <= '0;
    end else begin
      state <= state_next;
      if (pop) begin
        opl_addr <= fifo_rdata.addr;
        opl_din  <= fifo_rdata.data;
      end
      if (state == SETUP) hold_cnt <= HOLD_LOAD;
      else if (state == STROBE && hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
    end
  end

`ifdef OPL2_WQ_PACING_EN
  localparam int                MAX_WAIT  = (ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT;
  localparam int                WAIT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] ADDR_LOAD = WAIT_W'(ADDR_WAIT - 1);
  localparam logic [WAIT_W-1:0] DATA_LOAD = WAIT_W'(DATA_WAIT - 1);

  logic [WAIT_W-1:0] wait_cnt;

  // Recovery length follows the port of the write that just strobed.
  always_ff @(posedge clk_opl) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state == STROBE && hold_cnt == '0) begin
      wait_cnt <= opl_addr ? DATA_LOAD : ADDR_LOAD;
    end else if (state == WAIT && wait_cnt != '0) begin
      wait_cnt <= wait_cnt - 1'b1;
    end
  end

  assign wait_last = (wait_cnt == '0);
`else
  assign wait_last = 1'b1;
`endif

  assign opl_we = (state == STROBE);
  assign busy   = (level != '0) || (state != IDLE);

endmodule

// File: tb/tb_opl2_write_queue.sv
// Scoreboard bench for opl2_write_queue: replay order, strobe shape, spacing, full, flush, reset.
module tb_opl2_write_queue;
  import opl2_pkg::*;

  localparam int DEPTH = 16;
  localparam int WA    = 48;
  localparam int WD    = 330;
  localparam int HOLD  = 4;

  logic       clk_opl = 1'b0;
  logic       rst_n = 1'b0;
  logic       host_valid = 1'b0;
  logic       host_ready;
  logic       host_addr = 1'b0;
  logic [7:0] host_data = 8'h00;
  logic       flush = 1'b0;
  logic       opl_addr;
  logic [7:0] opl_din;
  logic       opl_we;
  logic [$clog2(DEPTH):0] level;
  logic       busy;

  int totalChecks = 0;
  int badChecks = 0;
  int cyc = 0;
  logic [8:0] sb[$];
  int rises[$];
  logic wePrev = 1'b0;
  logic [8:0] weLatched = '0;
  int weWidth = 0;
  int lastFall = -100;

  opl2_write_queue #(
    .DEPTH(DEPTH), .ADDR_WAIT(WA), .DATA_WAIT(WD), .WE_HOLD(HOLD)
  ) dut (
    .clk_opl    (clk_opl),
    .rst_n      (rst_n),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .host_addr  (host_addr),
    .host_data  (host_data),
    .flush      (flush),
    .opl_addr   (opl_addr),
    .opl_din    (opl_din),
    .opl_we     (opl_we),
    .level      (level),
    .busy       (busy)
  );

  always #5 clk_opl = ~clk_opl;
  always @(posedge clk_opl) cyc <= cyc + 1;

  function automatic int waitOf(input logic a);
`ifdef OPL2_WQ_PACING_EN
    return a ? WD : WA;
`else
    return 1;
`endif
  endfunction

  // Pops completed by edge e when the queue stays backlogged with a fixed spacing s.
  function automatic int popsBy(input int e, input int s);
    return (e >= 1) ? ((e - 1) / s + 1) : 0;
  endfunction

  task automatic checkOutput(input string tag, input int obs, input int exp);
    totalChecks++;
    if (obs != exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic applyStimulus(input logic a, input logic [7:0] d);
    checkOutput("push_ready", host_ready, 1);
    host_valid = 1'b1;
    host_addr  = a;
    host_data  = d;
    sb.push_back({a, d});
    @(negedge clk_opl);
    host_valid = 1'b0;
  endtask

  task automatic waitIdle(output int n);
    n = 0;
    while (busy && n < 20000) begin
      @(negedge clk_opl);
      n++;
    end
    if (busy) checkOutput("idle_timeout", busy, 0);
  endtask

  task automatic waitWeLow();
    int n = 0;
    while (opl_we && n < 50) begin
      @(negedge clk_opl);
      n++;
    end
    if (opl_we) checkOutput("we_low_timeout", opl_we, 0);
  endtask

  // Strobe monitor: entry order, stable bus during strobe, pulse width, low time.
  always @(negedge clk_opl) begin
    if (opl_we && !wePrev) begin
      rises.push_back(cyc);
      weLatched = {opl_addr, opl_din};
      weWidth = 1;
      checkOutput("we_low_time_ok", (cyc - lastFall) >= 2, 1);
      if (sb.size() == 0) checkOutput("we_without_entry", opl_we, 0);
      else checkOutput("we_entry", {opl_addr, opl_din}, sb.pop_front());
    end else if (opl_we && wePrev) begin
      weWidth++;
      checkOutput("we_bus_stable", {opl_addr, opl_din}, weLatched);
    end else if (!opl_we && wePrev) begin
      lastFall = cyc;
      checkOutput("we_width", weWidth, HOLD);
    end
    wePrev = opl_we;
  end

  initial begin
    repeat (60000) @(posedge clk_opl);
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    int e;
    int pushed;
    int expLvl;
    int s;

    // Reset values
    repeat (3) @(negedge clk_opl);
    checkOutput("rst_we", opl_we, 0);
    checkOutput("rst_level", level, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_ready", host_ready, 0);
    checkOutput("rst_addr", opl_addr, 0);
    checkOutput("rst_din", opl_din, 0);
    rst_n = 1'b1;
    @(negedge clk_opl);

    // Single write latency
    applyStimulus(1'b0, 8'h20);
    checkOutput("t1_level_e0", level, 1);
    @(negedge clk_opl);
    checkOutput("t1_addr_e1", opl_addr, 0);
    checkOutput("t1_din_e1", opl_din, 8'h20);
    checkOutput("t1_level_e1", level, 0);
    checkOutput("t1_we_e1", opl_we, 0);
    @(negedge clk_opl);
    checkOutput("t1_we_e2", opl_we, 1);
    waitWeLow();
    waitIdle(n);
    checkOutput("t1_busy_fall", n, waitOf(1'b0));

    // Backlog spacing and order
    rises.delete();
    applyStimulus(1'b0, 8'hB0);
    applyStimulus(1'b1, 8'h31);
    applyStimulus(1'b0, 8'hA0);
    waitIdle(n);
    checkOutput("t2_rise_count", rises.size(), 3);
    if (rises.size() >= 3) begin
      checkOutput("t2_space_0", rises[1] - rises[0], 1 + HOLD + waitOf(1'b0));
      checkOutput("t2_space_1", rises[2] - rises[1], 1 + HOLD + waitOf(1'b1));
    end
    checkOutput("t2_sb_empty", sb.size(), 0);

    // Fill to full while the replay drains at its own pace
    s = 1 + HOLD + waitOf(1'b0);
    pushed = 0;
    e = 0;
    expLvl = 0;
    while (expLvl < DEPTH && e < 200) begin
      applyStimulus(1'b0, 8'(e));
      pushed++;
      expLvl = pushed - popsBy(e, s);
      checkOutput("t3_fill_level", level, expLvl);
      e++;
    end
    checkOutput("t3_full_ready", host_ready, 0);
    host_valid = 1'b1;
    host_addr  = 1'b0;
    host_data  = 8'hEE;
    for (int k = 0; k < s + 2; k++) begin
      @(negedge clk_opl);
      expLvl = pushed - popsBy(e, s);
      e++;
      if (expLvl >= DEPTH) begin
        checkOutput("t3_full_level", level, DEPTH);
        checkOutput("t3_full_no_ready", host_ready, 0);
      end else begin
        host_valid = 1'b0;
        checkOutput("t3_after_pop_ready", host_ready, 1);
        checkOutput("t3_after_pop_level", level, DEPTH - 1);
        break;
      end
    end
    host_valid = 1'b0;
    waitIdle(n);
    checkOutput("t3_sb_empty", sb.size(), 0);

    // Flush during the strobe of the first entry
    rises.delete();
    applyStimulus(1'b1, 8'h11);
    for (int k = 0; k < 5; k++) applyStimulus(1'b0, 8'(8'h12 + k));
    checkOutput("t4_in_strobe", opl_we, 1);
    checkOutput("t4_level_pre", level, 5);
    flush      = 1'b1;
    host_valid = 1'b1;
    host_data  = 8'h77;
    #1;
    checkOutput("t4_flush_ready", host_ready, 0);
    @(negedge clk_opl);
    flush      = 1'b0;
    host_valid = 1'b0;
    sb.delete();
    checkOutput("t4_level_post", level, 0);
    checkOutput("t4_busy_post", busy, 1);
    waitIdle(n);
    checkOutput("t4_wait_full", n, waitOf(1'b1));
    repeat (20) @(negedge clk_opl);
    checkOutput("t4_rise_count", rises.size(), 1);

    // Reset while in WAIT
    applyStimulus(1'b1, 8'h41);
    applyStimulus(1'b0, 8'h42);
    applyStimulus(1'b0, 8'h43);
    repeat (4) @(negedge clk_opl);
    checkOutput("t5_in_wait_we", opl_we, 0);
    checkOutput("t5_in_wait_busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk_opl);
    sb.delete();
    checkOutput("t5_rst_we", opl_we, 0);
    checkOutput("t5_rst_level", level, 0);
    checkOutput("t5_rst_busy", busy, 0);
    checkOutput("t5_rst_ready", host_ready, 0);
    checkOutput("t5_rst_din", opl_din, 0);
    rst_n = 1'b1;
    #1;
    applyStimulus(1'b0, 8'h55);
    checkOutput("t5_level_after", level, 1);
    waitIdle(n);
    checkOutput("t5_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
